// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD adder.
//   state_t : controller states (IDLE, ADD, DONE)
//   BCD_MAX : largest legal decimal digit
//   BCD_ADJ : correction added to a digit sum above BCD_MAX
//   DIGIT_W : bits per BCD digit
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int BCD_MAX = 9;
    localparam int BCD_ADJ = 6;
    localparam int DIGIT_W = 4;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit decimal adder.
// Ports:
//   a, b : BCD digits (0..9)
//   cin  : decimal carry-in
//   s    : corrected BCD sum digit
//   cout : decimal carry-out
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] s,
    output logic               cout
);

    logic [DIGIT_W:0] sum5;
    logic [DIGIT_W:0] adj5;

    assign sum5 = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    // Adding 6 skips the six unused binary codes 10..15; the low nibble is the digit.
    assign adj5 = sum5 + (DIGIT_W + 1)'(BCD_ADJ);

    always_comb begin
        s    = sum5[DIGIT_W-1:0];
        cout = 1'b0;
        if (sum5 > (DIGIT_W + 1)'(BCD_MAX)) begin
            s    = adj5[DIGIT_W-1:0];
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, least-significant first.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   start    : request, sampled only while idle
//   in1, in2 : packed BCD operands (digit i at bits [4i+3:4i])
//   ci       : decimal carry-in
//   out, co  : registered BCD sum and decimal carry-out
//   n_err    : low when the last request contained a non-BCD digit
//   busy     : high while digits are being added
//   done     : one-cycle pulse when out/co/n_err have been updated
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [4*DIGITS-1:0]      in1,
    input  logic [4*DIGITS-1:0]      in2,
    input  logic                     ci,
    output logic [4*DIGITS-1:0]      out,
    output logic                     co,
    output logic                     n_err,
    output logic                     busy,
    output logic                     done
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_t             state;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               carry_r;
    logic               err_r;
    logic [IDX_W-1:0]   idx;

    logic [DIGIT_W-1:0] dsum;
    logic               dcout;
    logic [W+DIGIT_W-1:0] shift_cat;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX)) bad = 1'b1;
        end
        return bad;
    endfunction

    // Operands are shifted right each ADD cycle, so the current digit is always the low nibble.
    bcd_digit_add u_digit (
        .a    (a_r[DIGIT_W-1:0]),
        .b    (b_r[DIGIT_W-1:0]),
        .cin  (carry_r),
        .s    (dsum),
        .cout (dcout)
    );

    // New digit enters at the MSD end; after DIGITS shifts digit 0 sits at the LSD.
    assign shift_cat = {dsum, sum_r};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
            idx     <= '0;
            out     <= '0;
            co      <= 1'b0;
            n_err   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= in1;
                        b_r     <= in2;
                        carry_r <= ci;
                        sum_r   <= '0;
                        idx     <= '0;
                        if (has_bad_digit(in1) || has_bad_digit(in2)) begin
                            err_r <= 1'b1;
                            state <= DONE;
                        end else begin
                            err_r <= 1'b0;
                            busy  <= 1'b1;
                            state <= ADD;
                        end
                    end
                end
                ADD: begin
                    sum_r   <= shift_cat[W+DIGIT_W-1:DIGIT_W];
                    a_r     <= a_r >> DIGIT_W;
                    b_r     <= b_r >> DIGIT_W;
                    carry_r <= dcout;
                    idx     <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Result registers are committed here and done pulses alongside them.
                    done  <= 1'b1;
                    if (err_r) begin
                        out   <= '0;
                        co    <= 1'b0;
                        n_err <= 1'b0;
                    end else begin
                        out   <= sum_r;
                        co    <= carry_r;
                        n_err <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         ci;
    logic [W-1:0] out;
    logic         co;
    logic         n_err;
    logic         busy;
    logic         done;

    int tests;
    int fails;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .ci    (ci),
        .out   (out),
        .co    (co),
        .n_err (n_err),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present operands, let the capture edge T0 pass, drop start.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        @(negedge clk);
        in1   = a;
        in2   = b;
        ci    = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after T0 until done is seen (-1 on timeout) and busy cycles observed.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [W-1:0] exp_out, input logic exp_co,
                           input logic exp_nerr, input int exp_lat, input int exp_busy);
        int lat;
        int bc;
        // busy is visible right after T0 when the operands are valid
        start_op(a, b, c);
        bc = busy ? 1 : 0;
        begin
            int bc2;
            wait_done(lat, bc2);
            bc += bc2;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy cycles"}, 32'(bc), 32'(exp_busy));
        chk({tag, " out"}, 32'(out), 32'(exp_out));
        chk({tag, " co"}, 32'(co), 32'(exp_co));
        chk({tag, " n_err"}, 32'(n_err), 32'(exp_nerr));
        chk({tag, " busy at done"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int cnt;
        logic [W-1:0] seen_out;
        logic         seen_co;

        tests = 0;
        fails = 0;
        rst   = 1'b1;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        ci    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out", 32'(out), 32'(0));
        chk("reset co", 32'(co), 32'(0));
        chk("reset n_err", 32'(n_err), 32'(1));
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        @(negedge clk);
        rst = 1'b0;

        run_add("1234+5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b1, DIGITS + 1, DIGITS);
        run_add("9999+0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, DIGITS + 1, DIGITS);
        run_add("9999+9999+1", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b1, DIGITS + 1, DIGITS);

        // Reset in cycle 2 of ADD aborts the operation.
        start_op(16'h1111, 16'h2222, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("midrst out", 32'(out), 32'(0));
        chk("midrst co", 32'(co), 32'(0));
        chk("midrst n_err", 32'(n_err), 32'(1));
        chk("midrst busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        chk("midrst no done", 32'(cnt), 32'(0));
        run_add("after rst 1111+2222", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b1, DIGITS + 1, DIGITS);

        run_add("err 12A4", 16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1, 0);
        run_add("recover 0005+0004+1", 16'h0005, 16'h0004, 1'b1, 16'h0010, 1'b0, 1'b1, DIGITS + 1, DIGITS);

        // Second start and operand change during ADD must not disturb the captured operation.
        start_op(16'h1234, 16'h5678, 1'b1);
        @(posedge clk);
        #1;
        start = 1'b1;
        in1   = 16'h9999;
        @(posedge clk);
        #1;
        start = 1'b0;
        in1   = 16'h0000;
        cnt      = 0;
        seen_out = '0;
        seen_co  = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cnt++;
                seen_out = out;
                seen_co  = co;
            end
        end
        chk("ignore done count", 32'(cnt), 32'(1));
        chk("ignore out", 32'(seen_out), 32'(16'h6913));
        chk("ignore co", 32'(seen_co), 32'(0));
        chk("ignore out held", 32'(out), 32'(16'h6913));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
